// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the RAM access controller and its decoder.
package ram_ctrl_pkg;

    localparam int DATA_W_DEF = 17;
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } ctrl_state_t;

endpackage

// File: rtl/ram_onehot_dec.sv
// Address to one-hot word select; all-zero select and oor=1 when addr >= DEPTH.
module ram_onehot_dec
    import ram_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DEPTH-1:0]  onehot,
    output logic              oor
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

    // An address with no matching word is exactly the out-of-range case.
    assign oor = ~|onehot;

endmodule

// File: rtl/ram_access_ctrl.sv
// Request/response front end for the one-hot-selected RAM word array.
// Optional feature: define RAM_CTRL_PIPE_EN to accept a new request while a response completes.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata1,
    output logic [DATA_W-1:0] rsp_rdata2,
    output logic              rsp_err,
    output logic [DATA_W-1:0] ram_wd,
    output logic [DEPTH-1:0]  ram_ws,
    output logic [DEPTH-1:0]  ram_rs1,
    output logic [DEPTH-1:0]  ram_rs2,
    input  logic [DATA_W-1:0] ram_rd1,
    input  logic [DATA_W-1:0] ram_rd2
);

    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic [ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0] addr2_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DEPTH-1:0]  dec_ws;
    logic [DEPTH-1:0]  dec_rs1;
    logic [DEPTH-1:0]  dec_rs2;
    logic              oor_ws;
    logic              oor_rs1;
    logic              oor_rs2;
    logic              accept;

    ram_onehot_dec #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dec_ws (
        .addr   (addr1_q),
        .onehot (dec_ws),
        .oor    (oor_ws)
    );

    ram_onehot_dec #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dec_rs1 (
        .addr   (addr1_q),
        .onehot (dec_rs1),
        .oor    (oor_rs1)
    );

    ram_onehot_dec #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dec_rs2 (
        .addr   (addr2_q),
        .onehot (dec_rs2),
        .oor    (oor_rs2)
    );

    always_comb begin
        req_ready = 1'b0;
        if (rst_n) begin
            if (state == IDLE) begin
                req_ready = 1'b1;
            end
`ifdef RAM_CTRL_PIPE_EN
            else if (state == RESP && rsp_ready) begin
                req_ready = 1'b1;
            end
`endif
        end
    end

    assign accept    = req_valid & req_ready;
    assign rsp_valid = rst_n & (state == RESP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_we ? WRITE : READ;
            WRITE:   state_next = IDLE;
            READ:    state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = accept ? (req_we ? WRITE : READ) : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Selects are gated by reset so a write caught mid-flight never reaches the array.
    always_comb begin
        ram_ws  = '0;
        ram_rs1 = '0;
        ram_rs2 = '0;
        ram_wd  = '0;
        if (rst_n) begin
            if (state == WRITE) begin
                ram_wd = wdata_q;
                if (!oor_ws) begin
                    ram_ws = dec_ws;
                end
            end
            if (state == READ) begin
                ram_rs1 = dec_rs1;
                ram_rs2 = dec_rs2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr1_q    <= '0;
            addr2_q    <= '0;
            wdata_q    <= '0;
            rsp_rdata1 <= '0;
            rsp_rdata2 <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr1_q <= req_addr1;
                addr2_q <= req_addr2;
                wdata_q <= req_wdata;
            end
            if (state == READ) begin
                rsp_rdata1 <= oor_rs1 ? '0 : ram_rd1;
                rsp_rdata2 <= oor_rs2 ? '0 : ram_rd2;
                rsp_err    <= oor_rs1 | oor_rs2;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: two instances (DEPTH 16 and DEPTH 12) driven in lockstep.
module tb_ram_access_ctrl;

    localparam int DW = 17;
    localparam int DA = 16;
    localparam int DB = 12;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_clear;
    always #5 clk = ~clk;

    logic          req_valid;
    logic          req_we;
    logic          rsp_ready;
    logic [3:0]    req_addr1;
    logic [3:0]    req_addr2;
    logic [DW-1:0] req_wdata;

    logic          req_ready_a, rsp_valid_a, rsp_err_a;
    logic [DW-1:0] rdata1_a, rdata2_a, wd_a, rd1_a, rd2_a;
    logic [DA-1:0] ws_a, rs1_a, rs2_a;
    logic          req_ready_b, rsp_valid_b, rsp_err_b;
    logic [DW-1:0] rdata1_b, rdata2_b, wd_b, rd1_b, rd2_b;
    logic [DB-1:0] ws_b, rs1_b, rs2_b;

    logic [DW-1:0] mem_a [DA];
    logic [DW-1:0] mem_b [DB];
    logic [DW-1:0] ref_a [DA];
    logic [DW-1:0] ref_b [DB];

    int checks = 0;
    int errors = 0;

    ram_access_ctrl #(.DATA_W(DW), .DEPTH(DA), .ADDR_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr1(req_addr1), .req_addr2(req_addr2), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata1(rdata1_a),
        .rsp_rdata2(rdata2_a), .rsp_err(rsp_err_a), .ram_wd(wd_a), .ram_ws(ws_a),
        .ram_rs1(rs1_a), .ram_rs2(rs2_a), .ram_rd1(rd1_a), .ram_rd2(rd2_a)
    );

    ram_access_ctrl #(.DATA_W(DW), .DEPTH(DB), .ADDR_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr1(req_addr1), .req_addr2(req_addr2), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata1(rdata1_b),
        .rsp_rdata2(rdata2_b), .rsp_err(rsp_err_b), .ram_wd(wd_b), .ram_ws(ws_b),
        .ram_rs1(rs1_b), .ram_rs2(rs2_b), .ram_rd1(rd1_b), .ram_rd2(rd2_b)
    );

    // RAM arrays: write on the clock edge via ws, read combinationally via rs1/rs2.
    always @(posedge clk) begin
        for (int i = 0; i < DA; i++) begin
            if (mem_clear) mem_a[i] <= '0;
            else if (ws_a[i]) mem_a[i] <= wd_a;
        end
        for (int i = 0; i < DB; i++) begin
            if (mem_clear) mem_b[i] <= '0;
            else if (ws_b[i]) mem_b[i] <= wd_b;
        end
    end

    always_comb begin
        rd1_a = '0;
        rd2_a = '0;
        for (int i = 0; i < DA; i++) begin
            if (rs1_a[i]) rd1_a = rd1_a | mem_a[i];
            if (rs2_a[i]) rd2_a = rd2_a | mem_a[i];
        end
    end

    always_comb begin
        rd1_b = '0;
        rd2_b = '0;
        for (int i = 0; i < DB; i++) begin
            if (rs1_b[i]) rd1_b = rd1_b | mem_b[i];
            if (rs2_b[i]) rd2_b = rd2_b | mem_b[i];
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] onehot(input int a, input int d);
        return (a < d) ? (32'd1 << a) : 32'd0;
    endfunction

    function automatic logic [DW-1:0] model_rd_b(input logic [3:0] a);
        return (int'(a) < DB) ? ref_b[a] : '0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One complete transaction; read response is held hold extra cycles with rsp_ready low.
    task automatic applyStimulus(input logic we, input logic [3:0] a1, input logic [3:0] a2,
                                 input logic [DW-1:0] wd, input int hold,
                                 output logic [DW-1:0] o1a, output logic [DW-1:0] o2a,
                                 output logic oea, output logic [DW-1:0] o1b,
                                 output logic [DW-1:0] o2b, output logic oeb);
        int n;
        logic [DW-1:0] e1a, e2a, e1b, e2b;
        logic eea, eeb;
        o1a = '0; o2a = '0; oea = 1'b0; o1b = '0; o2b = '0; oeb = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr1 = a1; req_addr2 = a2;
        req_wdata = wd; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=no_ready expected=ready");
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (we) begin
            checkOutput("ws_a", 32'(ws_a), onehot(int'(a1), DA));
            checkOutput("ws_b", 32'(ws_b), onehot(int'(a1), DB));
            checkOutput("wd_a", 32'(wd_a), 32'(wd));
            checkOutput("rs1_a_in_write", 32'(rs1_a), 32'd0);
            if (int'(a1) < DA) ref_a[a1] = wd;
            if (int'(a1) < DB) ref_b[a1] = wd;
            @(negedge clk);
            checkOutput("ws_a_after", 32'(ws_a), 32'd0);
            checkOutput("ws_b_after", 32'(ws_b), 32'd0);
        end else begin
            e1a = ref_a[a1];
            e2a = ref_a[a2];
            eea = 1'b0;
            e1b = model_rd_b(a1);
            e2b = model_rd_b(a2);
            eeb = (int'(a1) >= DB) || (int'(a2) >= DB);
            checkOutput("rs1_a", 32'(rs1_a), onehot(int'(a1), DA));
            checkOutput("rs2_a", 32'(rs2_a), onehot(int'(a2), DA));
            checkOutput("rs1_b", 32'(rs1_b), onehot(int'(a1), DB));
            checkOutput("rs2_b", 32'(rs2_b), onehot(int'(a2), DB));
            @(negedge clk);
            o1a = rdata1_a; o2a = rdata2_a; oea = rsp_err_a;
            o1b = rdata1_b; o2b = rdata2_b; oeb = rsp_err_b;
            for (int c = 0; c <= hold; c++) begin
                checkOutput("rsp_valid_a", 32'(rsp_valid_a), 32'd1);
                checkOutput("rsp_valid_b", 32'(rsp_valid_b), 32'd1);
                checkOutput("rdata1_a", 32'(rdata1_a), 32'(e1a));
                checkOutput("rdata2_a", 32'(rdata2_a), 32'(e2a));
                checkOutput("err_a", 32'(rsp_err_a), 32'(eea));
                checkOutput("rdata1_b", 32'(rdata1_b), 32'(e1b));
                checkOutput("rdata2_b", 32'(rdata2_b), 32'(e2b));
                checkOutput("err_b", 32'(rsp_err_b), 32'(eeb));
                checkOutput("req_ready_in_resp", 32'(req_ready_a), 32'd0);
                checkOutput("rs1_a_in_resp", 32'(rs1_a), 32'd0);
                if (c < hold) @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            checkOutput("rsp_valid_done", 32'(rsp_valid_a), 32'd0);
            checkOutput("req_ready_idle", 32'(req_ready_a), 32'd1);
        end
    endtask

    typedef struct packed {
        logic          we;
        logic [3:0]    a1;
        logic [3:0]    a2;
        logic [DW-1:0] wd;
        logic [7:0]    hold;
        logic [DW-1:0] x1a;
        logic [DW-1:0] x2a;
        logic          xea;
        logic [DW-1:0] x1b;
        logic [DW-1:0] x2b;
        logic          xeb;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [DW-1:0] o1a, o2a, o1b, o2b;
        logic oea, oeb;
        int first, fifth, acc, hs, hs_at5, cyc;

        vecs[0] = '{1'b1, 4'd3,  4'd0,  17'h1ABCD, 8'd0, 17'h0, 17'h0, 1'b0, 17'h0, 17'h0, 1'b0};
        vecs[1] = '{1'b0, 4'd3,  4'd0,  17'h0,     8'd0, 17'h1ABCD, 17'h0, 1'b0, 17'h1ABCD, 17'h0, 1'b0};
        vecs[2] = '{1'b1, 4'd5,  4'd0,  17'h00055, 8'd0, 17'h0, 17'h0, 1'b0, 17'h0, 17'h0, 1'b0};
        vecs[3] = '{1'b1, 4'd9,  4'd0,  17'h1FFFF, 8'd0, 17'h0, 17'h0, 1'b0, 17'h0, 17'h0, 1'b0};
        vecs[4] = '{1'b0, 4'd9,  4'd5,  17'h0,     8'd4, 17'h1FFFF, 17'h00055, 1'b0, 17'h1FFFF, 17'h00055, 1'b0};
        vecs[5] = '{1'b0, 4'd13, 4'd2,  17'h0,     8'd0, 17'h0, 17'h0, 1'b0, 17'h0, 17'h0, 1'b1};
        vecs[6] = '{1'b1, 4'd14, 4'd0,  17'h12345, 8'd0, 17'h0, 17'h0, 1'b0, 17'h0, 17'h0, 1'b0};
        vecs[7] = '{1'b0, 4'd14, 4'd14, 17'h0,     8'd1, 17'h12345, 17'h12345, 1'b0, 17'h0, 17'h0, 1'b1};
        vecs[8] = '{1'b1, 4'd13, 4'd0,  17'h0AAAA, 8'd0, 17'h0, 17'h0, 1'b0, 17'h0, 17'h0, 1'b0};
        vecs[9] = '{1'b0, 4'd13, 4'd9,  17'h0,     8'd0, 17'h0AAAA, 17'h1FFFF, 1'b0, 17'h0, 17'h1FFFF, 1'b1};

        for (int i = 0; i < DA; i++) ref_a[i] = '0;
        for (int i = 0; i < DB; i++) ref_b[i] = '0;

        rst_n = 1'b0; mem_clear = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr1 = '0; req_addr2 = '0; req_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        mem_clear = 1'b0;
        checkOutput("reset_req_ready", 32'(req_ready_a), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid_a), 32'd0);
        checkOutput("reset_rdata1", 32'(rdata1_a), 32'd0);
        checkOutput("reset_rdata2", 32'(rdata2_a), 32'd0);
        checkOutput("reset_err", 32'(rsp_err_a), 32'd0);
        checkOutput("reset_ws", 32'(ws_a), 32'd0);
        checkOutput("reset_rs1", 32'(rs1_a), 32'd0);
        checkOutput("reset_rs2", 32'(rs2_a), 32'd0);
        checkOutput("reset_wd", 32'(wd_a), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_ready", 32'(req_ready_a), 32'd1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].we, vecs[i].a1, vecs[i].a2, vecs[i].wd, int'(vecs[i].hold),
                          o1a, o2a, oea, o1b, o2b, oeb);
            if (!vecs[i].we) begin
                checkOutput($sformatf("vec%0d_rdata1_a", i), 32'(o1a), 32'(vecs[i].x1a));
                checkOutput($sformatf("vec%0d_rdata2_a", i), 32'(o2a), 32'(vecs[i].x2a));
                checkOutput($sformatf("vec%0d_err_a", i), 32'(oea), 32'(vecs[i].xea));
                checkOutput($sformatf("vec%0d_rdata1_b", i), 32'(o1b), 32'(vecs[i].x1b));
                checkOutput($sformatf("vec%0d_rdata2_b", i), 32'(o2b), 32'(vecs[i].x2b));
                checkOutput($sformatf("vec%0d_err_b", i), 32'(oeb), 32'(vecs[i].xeb));
            end
        end

        // Reset while a read is in flight: response is discarded.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr1 = 4'd9; req_addr2 = 4'd5;
        checkOutput("rst_read_ready", 32'(req_ready_a), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rst_read_rs1", 32'(rs1_a), onehot(9, DA));
        rst_n = 1'b0;
        #1;
        checkOutput("rst_read_rs1_gated", 32'(rs1_a), 32'd0);
        @(negedge clk);
        checkOutput("rst_read_rsp_valid", 32'(rsp_valid_a), 32'd0);
        checkOutput("rst_read_rs2", 32'(rs2_a), 32'd0);
        checkOutput("rst_read_req_ready", 32'(req_ready_a), 32'd0);
        checkOutput("rst_read_rdata1", 32'(rdata1_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_read_idle_ready", 32'(req_ready_a), 32'd1);
        checkOutput("rst_read_idle_valid", 32'(rsp_valid_a), 32'd0);

        // Reset while a write is in flight: the word must keep its old value.
        req_valid = 1'b1; req_we = 1'b1; req_addr1 = 4'd9; req_wdata = 17'h00001;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_write_ws", 32'(ws_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'd9, 4'd9, '0, 0, o1a, o2a, oea, o1b, o2b, oeb);
        checkOutput("rst_write_kept", 32'(o1a), 32'h1FFFF);

        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), DW'($urandom),
                          int'($urandom_range(0, 2)), o1a, o2a, oea, o1b, o2b, oeb);
        end

        // Streaming reads: offset from first to fifth acceptance is the 4-response period.
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr1 = 4'd9; req_addr2 = 4'd5;
        first = -1; fifth = -1; acc = 0; hs = 0; hs_at5 = 0; cyc = 0;
        while (cyc < 60 && hs < 5) begin
            if (acc >= 5) req_valid = 1'b0;
            #1;
            if (rsp_valid_a && rsp_ready) begin
                hs++;
                checkOutput("pipe_rdata1", 32'(rdata1_a), 32'(ref_a[9]));
                checkOutput("pipe_rdata2", 32'(rdata2_a), 32'(ref_a[5]));
            end
            if (req_valid && req_ready_a) begin
                acc++;
                if (acc == 1) first = cyc;
                if (acc == 5) begin
                    fifth = cyc;
                    hs_at5 = hs;
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        checkOutput("pipe_responses", 32'(hs), 32'd5);
        checkOutput("pipe_resp_before_fifth", 32'(hs_at5), 32'd4);
`ifdef RAM_CTRL_PIPE_EN
        checkOutput("pipe_period", 32'(fifth - first), 32'd8);
`else
        checkOutput("pipe_period", 32'(fifth - first), 32'd12);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
